alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester controller that time-shares the single combinational ALU between two clients, for example the integer execute path and the branch-compare path. It arbitrates round-robin, registers the operands and opcode driven into the ALU, captures the result and zero flag, and returns them to the owning requester over a valid/ready handshake. The ALU stays a separate combinational instance: this block drives its `a`/`b`/`ALUcontrol` inputs and samples its `result`/`zero` outputs.

## Interface
- `DATA_W`, default 32: operand/result width; must match the ALU.
- `OP_W`, default 6: opcode width; carries `ALU_pkg` `ALU_control_signals` encodings unmodified.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  DATA_W  requester 0 operands.
- `req0_op`  in  OP_W  requester 0 ALU opcode.
- `resp0_valid`  out  1  result for requester 0 available.
- `resp0_ready`  in  1  requester 0 consumes result.
- `resp0_result`  out  DATA_W  result returned to requester 0.
- `resp0_zero`  out  1  zero flag returned to requester 0.
- `req1_*` / `resp1_*`: identical set for requester 1.
- `alu_a`, `alu_b`  out  DATA_W  to ALU `a`, `b`.
- `alu_ctrl`  out  OP_W  to ALU `ALUcontrol`.
- `alu_result`  in  DATA_W  from ALU `result`.
- `alu_zero`  in  1  from ALU `zero`.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - EXEC: ALU evaluates the registered operands.
  - RESP: holds the result until it is consumed.
- Internal registers:
  - `opa`, `opb`, `opc`: operand and opcode registers.
  - `owner`: 1 bit, identifies the requester being served.
  - `last_grant`: 1 bit, round-robin pointer.
  - `res`, `zf`: captured result and zero flag.
- IDLE arbitration:
  - Only one valid request: that requester is granted.
  - Both valid: grant the requester that is not `last_grant`.
  - Grant means `reqN_ready` = 1 combinationally in the same cycle. At most one ready is high at a time, and readies are high only in IDLE.
  - On a grant:
    - `opa`, `opb`, `opc` ← the granted requester's `a`, `b`, `op`.
    - `owner` ← N; `last_grant` ← N.
    - Next state is EXEC.
  - No valid request: stay in IDLE.
- EXEC (always one cycle): `res` ← `alu_result`, `zf` ← `alu_zero`; next state is RESP.
- RESP:
  - `resp[owner]_valid` = 1; the other `resp_valid` = 0.
  - When `resp[owner]_ready` = 1, the handshake completes and the next state is IDLE. Otherwise stay in RESP with `res`/`zf` held stable.
- Output drive:
  - `alu_a`/`alu_b`/`alu_ctrl` are driven from `opa`/`opb`/`opc` at all times.
  - `resp0_result`/`resp1_result` are both driven from `res`, and both zero outputs from `zf`. Only `resp_valid` qualifies them.
- The opcode is not decoded or validated. An unhandled opcode produces whatever the ALU returns (X), and that value is passed through unchanged.
- A requester is expected to hold `valid` and its operands stable until it sees `ready`. The block captures the operands only in the handshake cycle.

## Timing
- Reset values:
  - State: IDLE.
  - `opa`, `opb`, `opc`, `res`: 0.
  - `zf`, `owner`: 0.
  - `last_grant`: 1, so requester 0 wins the first contention.
  - All `ready`/`resp_valid` outputs: 0.
- Latency: request handshake at cycle T → `resp_valid` = 1 at cycle T+2.
- Minimum request-to-request spacing is 3 cycles: with `resp_ready` held high, the next grant is possible at T+3.
- Backpressure: each cycle in which `resp_ready` is low adds one cycle, and no new request is accepted meanwhile.
- `rst` asserted in any state:
  - The next cycle is in IDLE with all outputs at their reset values.
  - An in-flight operation is discarded and no response is issued.
  - `rst` overrides a simultaneous handshake.
- `reqN_valid` seen while the block is in EXEC or RESP is ignored, with no state effect. Arbitration is re-evaluated on the cycle the block returns to IDLE.

## Test plan
- **Single ADD.** After reset, `req0` ADD a=5, b=3, with `resp0_ready` = 1 → `req0_ready` at T, `resp0_valid` at T+2, result=8, zero=0, `resp1_valid` stays 0.
- **Zero flag.** `req1` SUB a=b=0x1234 → `resp1_result`=0, `resp1_zero`=1 at T+2.
- **Contention.** Both valid continuously from reset, req0 ADD 1+1, req1 XOR 0xF^0xF0:
  - Grants alternate 0,1,0,1 at cycles T, T+3, T+6, T+9.
  - Results are 2 and 0xFF.
  - A `ready` is never high for both requesters in the same cycle.
- **Backpressure.** `req1` SLT a=0xFFFFFFFF, b=1, with `resp1_ready` low for 4 cycles:
  - `resp1_valid`=1 and result=1 held for 5 cycles.
  - A `req0_valid` raised during this window gets no ready until the cycle after the `resp1` handshake.
- **Reset mid-operation.** Assert `rst` in EXEC:
  - Next cycle: IDLE, all `resp_valid`=0, `alu_a`/`alu_b`/`alu_ctrl`=0.
  - The aborted result is never delivered.
  - The next contention grants req0.
- **Shift pass-through.** `req0` SRA a=0x80000000, b=4 → `alu_ctrl` equals the SRA encoding during EXEC, result=0xF8000000.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Time-shares one combinational ALU between two requesters. A round-robin
//   arbiter picks a requester in IDLE, its operands/opcode are registered and
//   driven into the ALU, the result and zero flag are captured one cycle later
//   and held on a valid/ready response channel back to the owning requester.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready            request handshake, N = 0,1
//   reqN_a/b/op                 operands and opcode for requester N
//   respN_valid/ready           response handshake, N = 0,1
//   respN_result/zero           captured result / zero flag (shared registers)
//   alu_a/b/ctrl                registered operands/opcode toward the ALU
//   alu_result/zero             combinational ALU outputs
module alu_share_ctrl #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } req_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] opa, opb, res;
    logic [OP_W-1:0]   opc;
    logic              owner, last_grant, zf;
    logic              gnt_vld, gnt_sel;
    req_t              req_sel;

    // Round-robin pick. Suppressed while rst is high so a requester never
    // sees a handshake that reset is about to discard.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_sel = ~last_grant;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b0;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    assign req_sel = gnt_sel ? req_t'{req1_a, req1_b, req1_op}
                             : req_t'{req0_a, req0_b, req0_op};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx    = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    req0_ready = ~gnt_sel;
                    req1_ready = gnt_sel;
                    state_nx   = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                // A response pending during reset is dropped, not offered.
                if (!rst) begin
                    resp0_valid = ~owner;
                    resp1_valid = owner;
                end
                if (owner ? resp1_ready : resp0_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand, ownership and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            opa        <= '0;
            opb        <= '0;
            opc        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;  // requester 0 wins the first contention
            res        <= '0;
            zf         <= 1'b0;
        end else begin
            if (gnt_vld) begin
                opa        <= req_sel.a;
                opb        <= req_sel.b;
                opc        <= req_sel.op;
                owner      <= gnt_sel;
                last_grant <= gnt_sel;
            end
            if (state == EXEC) begin
                res <= alu_result;
                zf  <= alu_zero;
            end
        end
    end

    assign alu_a        = opa;
    assign alu_b        = opb;
    assign alu_ctrl     = opc;
    assign resp0_result = res;
    assign resp1_result = res;
    assign resp0_zero   = zf;
    assign resp1_zero   = zf;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    localparam int DW = 32;
    localparam int OW = 6;

    localparam logic [OW-1:0] OP_ADD = 6'h02;
    localparam logic [OW-1:0] OP_SUB = 6'h06;
    localparam logic [OW-1:0] OP_XOR = 6'h03;
    localparam logic [OW-1:0] OP_SLT = 6'h07;
    localparam logic [OW-1:0] OP_SRA = 6'h0D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
    logic          req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
    logic [OW-1:0] req0_op, req1_op, alu_ctrl;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          alu_zero;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Stand-in for the external combinational ALU
    always_comb begin
        case (alu_ctrl)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            OP_SRA:  alu_result = $signed(alu_a) >>> alu_b[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        bit            p;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
        logic [DW-1:0] r;
        bit            z;
    } vec_t;

    vec_t          vt[7];
    logic [DW:0]   q0[$], q1[$];   // {zero, result}
    int            gq[$], gc[$];   // grant port / grant cycle
    int            checks = 0, errors = 0;
    int            cyc = 0;
    int            gcl[2];
    logic [1:0]    rv_d = 2'b00;
    bit            lg_pend = 1'b0;
    int            lg_cyc;
    logic [DW-1:0] lg_a, lg_b;
    logic [OW-1:0] lg_op;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: exclusivity, EXEC-cycle ALU drive, latency, scoreboard pop
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready || req1_ready) chk("one_ready", {31'b0, req0_ready & req1_ready}, 0);
            if (resp0_valid || resp1_valid) chk("one_resp", {31'b0, resp0_valid & resp1_valid}, 0);
            if (lg_pend && cyc == lg_cyc + 1) begin
                chk("exec_alu_a", alu_a, lg_a);
                chk("exec_alu_b", alu_b, lg_b);
                chk("exec_alu_ctrl", {26'b0, alu_ctrl}, {26'b0, lg_op});
                lg_pend = 1'b0;
            end
            if (req0_valid && req0_ready) begin
                gq.push_back(0); gc.push_back(cyc); gcl[0] = cyc;
                lg_pend = 1'b1; lg_cyc = cyc; lg_a = req0_a; lg_b = req0_b; lg_op = req0_op;
            end
            if (req1_valid && req1_ready) begin
                gq.push_back(1); gc.push_back(cyc); gcl[1] = cyc;
                lg_pend = 1'b1; lg_cyc = cyc; lg_a = req1_a; lg_b = req1_b; lg_op = req1_op;
            end
            if (resp0_valid && !rv_d[0]) chk("latency0", cyc - gcl[0], 2);
            if (resp1_valid && !rv_d[1]) chk("latency1", cyc - gcl[1], 2);
            if (resp0_valid && resp0_ready) begin
                if (q0.size() == 0) fail_now("unexpected_resp0");
                else begin
                    logic [DW:0] e;
                    e = q0.pop_front();
                    chk("resp0_result", resp0_result, e[DW-1:0]);
                    chk("resp0_zero", {31'b0, resp0_zero}, {31'b0, e[DW]});
                end
            end
            if (resp1_valid && resp1_ready) begin
                if (q1.size() == 0) fail_now("unexpected_resp1");
                else begin
                    logic [DW:0] e;
                    e = q1.pop_front();
                    chk("resp1_result", resp1_result, e[DW-1:0]);
                    chk("resp1_zero", {31'b0, resp1_zero}, {31'b0, e[DW]});
                end
            end
        end
        rv_d = {resp1_valid, resp0_valid};
    end

    task automatic set_req(input bit p, input bit v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OW-1:0] op);
        if (p) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
        else   begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
    endtask

    // Starts just after a posedge; returns just after the handshake edge
    task automatic do_req(input vec_t v);
        bit ok = 1'b0;
        if (v.p) q1.push_back({v.z, v.r}); else q0.push_back({v.z, v.r});
        set_req(v.p, 1'b1, v.a, v.b, v.op);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (v.p ? req1_ready : req0_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("ready_timeout");
        @(posedge clk); #1;
        set_req(v.p, 1'b0, '0, '0, '0);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (q0.size() == 0 && q1.size() == 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Both requesters held valid until n grants; expects 0,1,0,1... spaced 3
    task automatic contend(input int n);
        int  base = gq.size();
        bit  ok   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) q0.push_back({1'b0, 32'd2});
            else            q1.push_back({1'b0, 32'hFF});
        end
        set_req(0, 1'b1, 32'd1, 32'd1, OP_ADD);
        set_req(1, 1'b1, 32'h0F, 32'hF0, OP_XOR);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gq.size() >= base + n) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        if (!ok) fail_now("contend_timeout");
        else begin
            for (int i = 0; i < n; i++) begin
                chk("grant_order", gq[base+i], i % 2);
                if (i > 0) chk("grant_spacing", gc[base+i] - gc[base+i-1], 3);
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 32'd5,        32'd3,        OP_ADD, 32'd8,        1'b0};
        vt[1] = '{1'b1, 32'h1234,     32'h1234,     OP_SUB, 32'd0,        1'b1};
        vt[2] = '{1'b0, 32'h80000000, 32'd4,        OP_SRA, 32'hF8000000, 1'b0};
        vt[3] = '{1'b1, 32'h0F,       32'hF0,       OP_XOR, 32'hFF,       1'b0};
        vt[4] = '{1'b0, 32'hFFFFFFFF, 32'd1,        OP_SLT, 32'd1,        1'b0};
        vt[5] = '{1'b1, 32'hFFFFFFFF, 32'd1,        OP_ADD, 32'd0,        1'b1};
        vt[6] = '{1'b0, 32'd3,        32'd5,        OP_SUB, 32'hFFFFFFFE, 1'b0};

        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", {31'b0, req0_ready}, 0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 0);
        chk("rst_resp0_valid", {31'b0, resp0_valid}, 0);
        chk("rst_resp1_valid", {31'b0, resp1_valid}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_ctrl", {26'b0, alu_ctrl}, 0);
        chk("rst_result", resp0_result, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single transactions from the vector table
        for (int i = 0; i < 7; i++) begin
            do_req(vt[i]);
            drain();
        end

        // Contention straight after reset: req0 first, then alternating
        do_reset();
        contend(4);

        // Backpressure on requester 1 with req0 waiting
        resp1_ready = 1'b0;
        begin
            vec_t v = '{1'b1, 32'hFFFFFFFF, 32'd1, OP_SLT, 32'd1, 1'b0};
            bit   ok = 1'b0;
            do_req(v);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (resp1_valid) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("bp_resp_timeout");
            for (int k = 0; k < 5; k++) begin
                chk("bp_resp1_valid", {31'b0, resp1_valid}, 1);
                chk("bp_resp1_result", resp1_result, 1);
                chk("bp_req0_ready", {31'b0, req0_ready}, 0);
                @(posedge clk); #1;
                if (k == 0) begin
                    q0.push_back({1'b0, 32'd4});
                    set_req(0, 1'b1, 32'd2, 32'd2, OP_ADD);
                end
                if (k == 3) resp1_ready = 1'b1;
                @(negedge clk);
            end
            chk("bp_req0_ready_after", {31'b0, req0_ready}, 1);
            chk("bp_resp1_valid_after", {31'b0, resp1_valid}, 0);
            @(posedge clk); #1;
            set_req(0, 1'b0, '0, '0, '0);
            drain();
        end

        // Reset while in EXEC: operation dropped, next contention grants req0
        begin
            bit ok = 1'b0;
            set_req(0, 1'b1, 32'd7, 32'd7, OP_ADD);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (req0_ready) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("abort_ready_timeout");
            @(posedge clk); #1;
            set_req(0, 1'b0, '0, '0, '0);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("abort_resp0_valid", {31'b0, resp0_valid}, 0);
            chk("abort_resp1_valid", {31'b0, resp1_valid}, 0);
            chk("abort_alu_a", alu_a, 0);
            chk("abort_alu_b", alu_b, 0);
            chk("abort_alu_ctrl", {26'b0, alu_ctrl}, 0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("abort_no_resp", {31'b0, resp0_valid | resp1_valid}, 0);
            end
            @(posedge clk); #1;
            contend(2);
        end

        chk("scoreboard_empty", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
